// File: rtl/regs_wb_arbiter.sv
// Register-file writeback arbiter between execute (A) and load (B) paths, with a pending-load scoreboard.
// Define REGS_WB_ARB_RR_EN for round-robin contention handling; otherwise B has fixed priority.
module regs_wb_arbiter #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  input  logic [AddressBitWidth-1:0] a_rd,
  input  logic [DataBitWidth-1:0]    a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [AddressBitWidth-1:0] b_rd,
  input  logic [DataBitWidth-1:0]    b_data,
  output logic                       b_ready,
  input  logic                       issue_load,
  input  logic [AddressBitWidth-1:0] issue_rd,
  input  logic [AddressBitWidth-1:0] rs1,
  input  logic [AddressBitWidth-1:0] rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [AddressBitWidth-1:0] rd,
  output logic                       rd_write_enable,
  output logic [DataBitWidth-1:0]    rd_data_in
);

  localparam int NumRegs = 1 << AddressBitWidth;

  logic                       grant_b;
  logic                       accept;
  logic [AddressBitWidth-1:0] acc_rd;
  logic [DataBitWidth-1:0]    acc_data;
  logic                       from_b;
  logic [NumRegs-1:0]         busy_q;
  logic [NumRegs-1:0]         busy_d;

`ifdef REGS_WB_ARB_RR_EN
  typedef enum logic {PREFER_A, PREFER_B} rr_e;
  rr_e rr_q, rr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= PREFER_A;
    else        rr_q <= rr_d;
  end

  // Pointer moves only on contended cycles, away from the requester just served.
  always_comb begin
    rr_d    = rr_q;
    grant_b = b_valid;
    if (a_valid && b_valid) begin
      grant_b = (rr_q == PREFER_B);
      rr_d    = grant_b ? PREFER_A : PREFER_B;
    end
  end
`else
  always_comb begin
    grant_b = b_valid;
  end
`endif

  assign b_ready  = rst_n & b_valid & grant_b;
  assign a_ready  = rst_n & a_valid & ~grant_b;
  assign accept   = a_ready | b_ready;
  assign acc_rd   = b_ready ? b_rd   : a_rd;
  assign acc_data = b_ready ? b_data : a_data;

  // Writes to x0 are accepted but leave the output register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd              <= '0;
      rd_data_in      <= '0;
      rd_write_enable <= 1'b0;
      from_b          <= 1'b0;
    end else begin
      rd_write_enable <= 1'b0;
      from_b          <= 1'b0;
      if (accept && acc_rd != '0) begin
        rd              <= acc_rd;
        rd_data_in      <= acc_data;
        rd_write_enable <= 1'b1;
        from_b          <= b_ready;
      end
    end
  end

  // Set is applied after clear so a simultaneous issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (rd_write_enable && from_b) busy_d[rd] = 1'b0;
    if (issue_load && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: stimulus pushes expected writebacks, a negedge monitor checks them.
module tb_regs_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, issue_load = 1'b0;
  logic [AW-1:0] a_rd = '0, b_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, rs1_busy, rs2_busy, rd_write_enable;
  logic [AW-1:0] rd;
  logic [DW-1:0] rd_data_in;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } wb_t;

  wb_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;

  regs_wb_arbiter #(.AddressBitWidth(AW), .DataBitWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_load(issue_load), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .rd_write_enable(rd_write_enable), .rd_data_in(rd_data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wb_t e;
    e.rd = r; e.data = d; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rd}, '0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rd", {27'd0, rd}, {27'd0, e.rd});
        check("wb_data", rd_data_in, e.data);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_grant [4];
`ifdef REGS_WB_ARB_RR_EN
    exp_grant = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state, with a request pending to show readies stay low.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    #12;
    check("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    check("rst_we", {31'd0, rd_write_enable}, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    check("rst_data", rd_data_in, 32'd0);
    a_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single A request to x5.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    @(negedge clk);
    check("a_only_ready", {30'd0, a_ready, b_ready}, 32'd2);
    push(5'd5, 32'h11);
    tick();
    a_valid = 1'b0;
    tick();

    // Contention for four cycles.
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("contend_grant", {30'd0, a_ready, b_ready}, {30'd0, exp_grant[i]});
      if (exp_grant[i] == 2'b10) push(5'd1, 32'hA1);
      else                       push(5'd2, 32'hB2);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // Load scoreboard: set on issue, clear after B write retires.
    issue_load = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    @(negedge clk);
    check("busy7_before", {31'd0, rs1_busy}, 32'd0);
    tick();
    issue_load = 1'b0;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    @(negedge clk);
    check("busy7_set", {31'd0, rs1_busy}, 32'd1);
    check("busy7_rs2", {31'd0, rs2_busy}, 32'd1);
    check("b_only_ready", {30'd0, a_ready, b_ready}, 32'd1);
    push(5'd7, 32'h77);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    check("busy7_n1", {31'd0, rs1_busy}, 32'd1);
    tick();
    @(negedge clk);
    check("busy7_n2", {31'd0, rs1_busy}, 32'd0);

    // x0: accepted, no write; never busy.
    tick();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFF;
    issue_load = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    @(negedge clk);
    check("x0_ready", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    a_valid = 1'b0; issue_load = 1'b0;
    @(negedge clk);
    check("x0_no_we", {31'd0, rd_write_enable}, 32'd0);
    check("x0_busy", {31'd0, rs1_busy}, 32'd0);

    // A writes never clear busy.
    tick();
    issue_load = 1'b1; issue_rd = 5'd4; rs1 = 5'd4;
    tick();
    issue_load = 1'b0;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44;
    push(5'd4, 32'h44);
    tick();
    a_valid = 1'b0;
    tick();
    @(negedge clk);
    check("busy4_a_write", {31'd0, rs1_busy}, 32'd1);

    // Issue coincides with B write to same register: busy stays set.
    tick();
    issue_load = 1'b1; issue_rd = 5'd9; rs1 = 5'd9;
    tick();
    issue_load = 1'b0;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    push(5'd9, 32'h99);
    tick();
    b_valid = 1'b0;
    issue_load = 1'b1; issue_rd = 5'd9;
    tick();
    issue_load = 1'b0;
    @(negedge clk);
    check("busy9_set_wins", {31'd0, rs1_busy}, 32'd1);

    // Reset mid-cycle right after an acceptance.
    tick();
    issue_load = 1'b1; issue_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd9;
    tick();
    issue_load = 1'b0;
    a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
    @(negedge clk);
    check("pre_rst_ready", {30'd0, a_ready, b_ready}, 32'd2);
    check("pre_rst_busy3", {31'd0, rs1_busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, rd_write_enable}, 32'd0);
    check("mid_rst_rd", {27'd0, rd}, 32'd0);
    check("mid_rst_data", rd_data_in, 32'd0);
    check("mid_rst_busy3", {31'd0, rs1_busy}, 32'd0);
    check("mid_rst_busy9", {31'd0, rs2_busy}, 32'd0);
    check("mid_rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_we", {31'd0, rd_write_enable}, 32'd0);
      tick();
    end

    check("wb_pending", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
